console_tx_fifo: RTL and testbench
==================================

// Module: console_tx_fifo
// PURPOSE
//   Byte FIFO between the stack CPU's console-write instruction and the simpleuart data register.
//   The CPU pushes a byte in one cycle and continues without stalling on the 300-baud line.
//   A drain FSM hands bytes to the UART using its we/wait handshake.
//   Sits downstream of the CPU core and upstream of simpleuart (reg_dat_we/reg_dat_di/reg_dat_wait).
// PARAMETERS
//   DEPTH     16   FIFO entries; power of two, >= 2
//   LEVEL_W   $clog2(DEPTH)+1   occupancy counter width (derived, not overridden)
// PORTS
//   clk            in   1        system clock (16 MHz); single clock domain
//   resetn         in   1        asynchronous, active-low reset
//   push_valid     in   1        CPU offers push_data this cycle
//   push_data      in   8        byte to transmit
//   push_ready     out  1        FIFO not full; push accepted iff push_valid && push_ready
//   level          out  LEVEL_W  current occupancy, 0..DEPTH
//   overflow       out  1        sticky: push_valid seen while full
//   clr_overflow   in   1        clears overflow (wins over a same-cycle set)
//   uart_dat_we    out  1        to simpleuart reg_dat_we
//   uart_dat_di    out  32       to simpleuart reg_dat_di; {24'b0, byte}
//   uart_dat_wait  in   1        from simpleuart reg_dat_wait
// BEHAVIOUR
//   Reset (async assert, sync release): rd/wr ptrs 0, level 0, push_ready 1, overflow 0,
//     uart_dat_we 0, uart_dat_di 0, FSM IDLE. Reset mid-send drops we at once; queued bytes are discarded.
//   Push: write at wr_ptr, wr_ptr wraps mod DEPTH; level +1 next cycle.
//     push_ready = (level != DEPTH), combinational from level.
//   Push while full: data dropped, overflow <= 1.
//   Drain FSM, all outputs registered:
//     IDLE: if level != 0 -> uart_dat_di <= {24'b0, mem[rd_ptr]}, uart_dat_we <= 1, -> SEND.
//     SEND: hold we and di stable while uart_dat_wait = 1.
//       On the first cycle with we=1 and wait=0 the byte is accepted: pop (rd_ptr+1 mod DEPTH),
//       uart_dat_we <= 0, -> IDLE.
//   Minimum one we-low cycle between bytes. Push-to-we latency on an empty FIFO is 2 cycles.
//   Simultaneous push and pop: level unchanged. Push at full with a same-cycle pop is still refused,
//     because push_ready is evaluated before the pop.
//   Byte order is strictly FIFO. Pointers are LEVEL_W-1 bits and wrap naturally.
// CONFIGURATION
//   CONSOLE_TX_CRLF_EN defined: when the head byte is 8'h0A and the internal cr_sent flag is 0,
//     IDLE loads 8'h0D and does not pop. Its acceptance sets cr_sent.
//     The following send of 8'h0A pops and clears cr_sent. Reset clears cr_sent.
//     Each LF therefore costs two UART transfers.
//   CONSOLE_TX_CRLF_EN undefined: bytes are sent verbatim; no cr_sent register exists.
// STRUCTURE
//   Package console_pkg: BYTE_W=8, ASCII_CR=8'h0D, ASCII_LF=8'h0A,
//     and the drain state enum (TX_IDLE, TX_SEND).
//   Sub-module console_fifo_mem: DEPTH x 8 register array, one write port, async read at rd_ptr.
//   The FSM, pointers and level counter live in console_tx_fifo.
// TESTING
//   1. Push 8'h41 into an empty FIFO; wait=0 -> we=1 with di=32'h41 two cycles later, one cycle only; level returns to 0.
//   2. Push 16 bytes 0x00..0x0F back-to-back, wait held 1 -> push_ready=0 after the 16th push.
//      A 17th push sets overflow=1, level=16. clr_overflow -> 0.
//   3. Hold wait=1 for 100 cycles mid-send -> we and di stable throughout; exactly one pop when wait falls.
//   4. Push 0x0A; with CONSOLE_TX_CRLF_EN the UART sees 0x0D then 0x0A; without it, only 0x0A.
//   5. Assert resetn=0 while we=1 with 5 bytes queued -> we=0 immediately, level=0, push_ready=1.
//   6. At level=DEPTH-1, push and accept a byte in the same cycle -> level stays DEPTH-1 and order is preserved.

Source files
------------

// File: rtl/console_pkg.sv
// Shared constants and drain-FSM state type for the console transmit FIFO.
package console_pkg;

    localparam int          BYTE_W   = 8;
    localparam logic [7:0]  ASCII_CR = 8'h0D;
    localparam logic [7:0]  ASCII_LF = 8'h0A;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_SEND = 1'b1
    } tx_state_e;

endpackage

// File: rtl/console_fifo_mem.sv
// DEPTH x BYTE_W register array: one synchronous write port, asynchronous read port.
module console_fifo_mem
    import console_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [BYTE_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [BYTE_W-1:0] o_rdata
);

    logic [BYTE_W-1:0] r_mem [DEPTH];

    // Storage write; contents are don't-care until the level counter covers them.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/console_tx_fifo.sv
// Byte FIFO feeding simpleuart via its we/wait handshake.
// Define CONSOLE_TX_CRLF_EN to expand every LF into a CR, LF pair on the line.
module console_tx_fifo
    import console_pkg::*;
#(
    parameter  int DEPTH   = 16,
    localparam int LEVEL_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               push_valid,
    input  logic [7:0]         push_data,
    output logic               push_ready,
    output logic [LEVEL_W-1:0] level,
    output logic               overflow,
    input  logic               clr_overflow,
    output logic               uart_dat_we,
    output logic [31:0]        uart_dat_di,
    input  logic               uart_dat_wait
);

    localparam int PTR_W = LEVEL_W - 1;

    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [LEVEL_W-1:0] r_level;
    logic               r_overflow;
    tx_state_e          r_state;
    logic               r_we;
    logic [31:0]        r_di;

    tx_state_e          w_state_nxt;
    logic               w_we_nxt;
    logic [31:0]        w_di_nxt;
    logic               w_push;
    logic               w_pop;
    logic [BYTE_W-1:0]  w_head;

`ifdef CONSOLE_TX_CRLF_EN
    logic               r_cr_sent;
    logic               r_send_cr;
    logic               w_send_cr_nxt;
    logic               w_cr_set;
`endif

    assign push_ready  = (r_level != LEVEL_W'(DEPTH));
    assign w_push      = push_valid && push_ready;
    assign level       = r_level;
    assign overflow    = r_overflow;
    assign uart_dat_we = r_we;
    assign uart_dat_di = r_di;

    console_fifo_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (push_data),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_head)
    );

    // Pointers, occupancy and sticky overflow; full is judged before any same-cycle pop.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr   <= {PTR_W{1'b0}};
            r_rd_ptr   <= {PTR_W{1'b0}};
            r_level    <= {LEVEL_W{1'b0}};
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LEVEL_W'(1);
                2'b01:   r_level <= r_level - LEVEL_W'(1);
                default: r_level <= r_level;
            endcase
            if (clr_overflow) begin
                r_overflow <= 1'b0;
            end else if (push_valid && !push_ready) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Drain FSM next state and next registered UART outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_we_nxt    = r_we;
        w_di_nxt    = r_di;
        w_pop       = 1'b0;
`ifdef CONSOLE_TX_CRLF_EN
        w_send_cr_nxt = r_send_cr;
        w_cr_set      = 1'b0;
`endif
        case (r_state)
            TX_IDLE: begin
                if (r_level != LEVEL_W'(0)) begin
                    w_we_nxt    = 1'b1;
                    w_state_nxt = TX_SEND;
`ifdef CONSOLE_TX_CRLF_EN
                    if ((w_head == ASCII_LF) && !r_cr_sent) begin
                        w_di_nxt      = {{(32-BYTE_W){1'b0}}, ASCII_CR};
                        w_send_cr_nxt = 1'b1;
                    end else begin
                        w_di_nxt      = {{(32-BYTE_W){1'b0}}, w_head};
                        w_send_cr_nxt = 1'b0;
                    end
`else
                    w_di_nxt    = {{(32-BYTE_W){1'b0}}, w_head};
`endif
                end else begin
                    w_we_nxt    = 1'b0;
                end
            end
            TX_SEND: begin
                if (r_we && !uart_dat_wait) begin
                    w_we_nxt    = 1'b0;
                    w_state_nxt = TX_IDLE;
`ifdef CONSOLE_TX_CRLF_EN
                    // An inserted CR leaves the LF at the head for the next transfer.
                    if (r_send_cr) begin
                        w_cr_set = 1'b1;
                    end else begin
                        w_pop    = 1'b1;
                    end
`else
                    w_pop       = 1'b1;
`endif
                end else begin
                    w_we_nxt    = r_we;
                end
            end
            default: begin
                w_we_nxt    = 1'b0;
                w_state_nxt = TX_IDLE;
            end
        endcase
    end

    // Drain FSM state and registered UART outputs; reset drops we immediately.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= TX_IDLE;
            r_we    <= 1'b0;
            r_di    <= 32'h0000_0000;
        end else begin
            r_state <= w_state_nxt;
            r_we    <= w_we_nxt;
            r_di    <= w_di_nxt;
        end
    end

`ifdef CONSOLE_TX_CRLF_EN
    // CR-insertion bookkeeping: cr_sent marks that the head LF already had its CR.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cr_sent <= 1'b0;
            r_send_cr <= 1'b0;
        end else begin
            r_send_cr <= w_send_cr_nxt;
            if (w_cr_set) begin
                r_cr_sent <= 1'b1;
            end else if (w_pop) begin
                r_cr_sent <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_console_tx_fifo.sv
// Randomized self-checking bench for console_tx_fifo against a queue-based reference model.
module tb_console_tx_fifo;

    localparam int DEPTH = 16;
`ifdef CONSOLE_TX_CRLF_EN
    localparam bit CRLF = 1'b1;
`else
    localparam bit CRLF = 1'b0;
`endif

    logic        clk;
    logic        resetn;
    logic        push_valid;
    logic [7:0]  push_data;
    logic        push_ready;
    logic [4:0]  level;
    logic        overflow;
    logic        clr_overflow;
    logic        uart_dat_we;
    logic [31:0] uart_dat_di;
    logic        uart_dat_wait;

    console_tx_fifo #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .push_valid    (push_valid),
        .push_data     (push_data),
        .push_ready    (push_ready),
        .level         (level),
        .overflow      (overflow),
        .clr_overflow  (clr_overflow),
        .uart_dat_we   (uart_dat_we),
        .uart_dat_di   (uart_dat_di),
        .uart_dat_wait (uart_dat_wait)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: queued bytes, sticky overflow, CR-already-sent flag, line log.
    logic [7:0]  m_q[$];
    logic        m_ovf;
    logic        m_cr;
    logic [7:0]  tx_log[$];
    logic        prev_hold;
    logic        prev_acc;
    logic [31:0] prev_di;
    int          idle_cnt;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ovf     = 1'b0;
        m_cr      = 1'b0;
        prev_hold = 1'b0;
        prev_acc  = 1'b0;
        prev_di   = 32'h0;
        idle_cnt  = 0;
    endtask

    // One clock: check settled outputs against the model, drive inputs, advance the model.
    task automatic step(input logic pv, input logic [7:0] pd, input logic wt, input logic clr);
        logic [7:0] exp_b;
        logic       acc;
        logic       full;
        @(negedge clk);
        check_eq("level", 32'(level), 32'(m_q.size()));
        check_eq("push_ready", 32'(push_ready), 32'(m_q.size() != DEPTH));
        check_eq("overflow", 32'(overflow), 32'(m_ovf));
        if (prev_hold) begin
            check_eq("hold_we", 32'(uart_dat_we), 32'(1));
            check_eq("hold_di", uart_dat_di, prev_di);
        end
        if (prev_acc) begin
            check_eq("gap_we", 32'(uart_dat_we), 32'(0));
        end
        exp_b = 8'h00;
        if (uart_dat_we) begin
            idle_cnt = 0;
            check_eq("we_nonempty", 32'(m_q.size() != 0), 32'(1));
            if (m_q.size() != 0) begin
                exp_b = (CRLF && m_q[0] == 8'h0A && !m_cr) ? 8'h0D : m_q[0];
                check_eq("di", uart_dat_di, {24'h0, exp_b});
            end
        end else if (m_q.size() != 0) begin
            idle_cnt++;
            check_eq("we_live", 32'(idle_cnt > 1), 32'(0));
        end else begin
            idle_cnt = 0;
        end
        push_valid    = pv;
        push_data     = pd;
        uart_dat_wait = wt;
        clr_overflow  = clr;
        acc  = uart_dat_we && !wt && (m_q.size() != 0);
        full = (m_q.size() == DEPTH);
        if (acc) begin
            tx_log.push_back(exp_b);
            if (CRLF && m_q[0] == 8'h0A && !m_cr) begin
                m_cr = 1'b1;
            end else begin
                void'(m_q.pop_front());
                m_cr = 1'b0;
            end
        end
        if (pv && !full) m_q.push_back(pd);
        if (clr) m_ovf = 1'b0;
        else if (pv && full) m_ovf = 1'b1;
        prev_hold = uart_dat_we && wt;
        prev_acc  = acc;
        prev_di   = uart_dat_di;
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && m_q.size() != 0; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check_eq("drain_level", 32'(level), 32'(0));
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn        = 1'b0;
        push_valid    = 1'b0;
        push_data     = 8'h00;
        clr_overflow  = 1'b0;
        uart_dat_wait = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_we", 32'(uart_dat_we), 32'(0));
        check_eq("rst_di", uart_dat_di, 32'h0);
        check_eq("rst_level", 32'(level), 32'(0));
        check_eq("rst_ready", 32'(push_ready), 32'(1));
        check_eq("rst_ovf", 32'(overflow), 32'(0));
        @(negedge clk);
        resetn = 1'b1;

        // 1: single byte latency and one-cycle strobe
        tx_log.delete();
        step(1'b1, 8'h41, 1'b0, 1'b0);
        after_edge();
        check_eq("t1_we_c1", 32'(uart_dat_we), 32'(0));
        step(1'b0, 8'h00, 1'b0, 1'b0);
        after_edge();
        check_eq("t1_we_c2", 32'(uart_dat_we), 32'(1));
        check_eq("t1_di", uart_dat_di, 32'h41);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        after_edge();
        check_eq("t1_we_off", 32'(uart_dat_we), 32'(0));
        check_eq("t1_level", 32'(level), 32'(0));
        drain();
        check_eq("t1_count", 32'(tx_log.size()), 32'(1));

        // 2: fill to full with the UART stalled, then overflow and clear
        tx_log.delete();
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b1, 1'b0);
        after_edge();
        check_eq("t2_ready_full", 32'(push_ready), 32'(0));
        check_eq("t2_level_full", 32'(level), 32'(DEPTH));
        step(1'b1, 8'hAA, 1'b1, 1'b0);
        after_edge();
        check_eq("t2_ovf_set", 32'(overflow), 32'(1));
        check_eq("t2_level_keep", 32'(level), 32'(DEPTH));
        step(1'b0, 8'h00, 1'b1, 1'b1);
        after_edge();
        check_eq("t2_ovf_clr", 32'(overflow), 32'(0));

        // 3: long stall mid-send, then exactly one pop
        for (int i = 0; i < 100; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        check_eq("t3_level_stall", 32'(level), 32'(DEPTH));
        step(1'b0, 8'h00, 1'b0, 1'b0);
        after_edge();
        check_eq("t3_level_pop", 32'(level), 32'(DEPTH - 1));
        check_eq("t3_we_off", 32'(uart_dat_we), 32'(0));

        // 6: push and accept in the same cycle at DEPTH-1
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b1, 8'h55, 1'b0, 1'b0);
        after_edge();
        check_eq("t6_level", 32'(level), 32'(DEPTH - 1));
        drain();
        check_eq("t6_first", 32'(tx_log[0]), 32'h00);
        check_eq("t6_second", 32'(tx_log[1]), 32'h01);
        check_eq("t6_last", 32'(tx_log[tx_log.size() - 1]), 32'h55);

        // Push at full with a same-cycle pop is refused
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h20 + i), 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b1, 8'h77, 1'b0, 1'b0);
        after_edge();
        check_eq("full_pop_level", 32'(level), 32'(DEPTH - 1));
        check_eq("full_pop_ovf", 32'(overflow), 32'(1));
        step(1'b0, 8'h00, 1'b0, 1'b1);
        drain();

        // 4: LF handling
        tx_log.delete();
        step(1'b1, 8'h0A, 1'b0, 1'b0);
        drain();
        check_eq("t4_count", 32'(tx_log.size()), CRLF ? 32'd2 : 32'd1);
        check_eq("t4_first", 32'(tx_log[0]), CRLF ? 32'h0D : 32'h0A);
        check_eq("t4_last", 32'(tx_log[tx_log.size() - 1]), 32'h0A);

        // 5: reset while sending with bytes queued
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h60 + i), 1'b1, 1'b0);
        after_edge();
        check_eq("t5_we_pre", 32'(uart_dat_we), 32'(1));
        #2;
        resetn = 1'b0;
        #1;
        check_eq("t5_we_rst", 32'(uart_dat_we), 32'(0));
        check_eq("t5_level_rst", 32'(level), 32'(0));
        check_eq("t5_ready_rst", 32'(push_ready), 32'(1));
        model_reset();
        push_valid = 1'b0;
        uart_dat_wait = 1'b0;
        @(negedge clk);
        resetn = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0) ? 8'h0A : 8'($urandom),
                 1'($urandom_range(0, 9) < 3),
                 1'($urandom_range(0, 49) == 0));
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
